clk_div_monitor: RTL
====================

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the period, phase and high-time counters.
REQ-002 Parameter LOCK_COUNT, default 4: consecutive matching periods required to assert locked.
REQ-003 Parameter TOL, default 1: maximum allowed |period - reference| in clk cycles for a period to count as a match.
REQ-004 clk  input  1  fast system clock; all logic is on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 div_in  input  1  divided clock to monitor; asynchronous to clk.
REQ-007 rise_pulse  output  1  one-cycle pulse per detected div_in rising edge.
REQ-008 fall_pulse  output  1  one-cycle pulse per detected div_in falling edge.
REQ-009 phase  output  CNT_W  clk cycles since the last rise_pulse.
REQ-010 period  output  CNT_W  last measured rise-to-rise interval, in clk cycles.
REQ-011 high_time  output  CNT_W  last measured rise-to-fall interval, in clk cycles.
REQ-012 locked  output  1  high while the div_in period is stable.
REQ-013 stall  output  1  sticky flag: div_in showed no rising edge within 2^CNT_W-1 cycles.

Function
REQ-014 div_in SHALL pass through a 2-flop synchronizer followed by an edge register.
REQ-015 rise_pulse/fall_pulse SHALL assert on the 3rd clk edge after div_in changes, provided the change meets setup at the first flop.
REQ-016 rise_pulse and fall_pulse SHALL never be high in the same cycle.
REQ-017 phase SHALL be 0 in each cycle where rise_pulse is high.
REQ-018 Otherwise phase SHALL increment by 1 per cycle, saturating at 2^CNT_W-1.
REQ-019 On rise_pulse, period SHALL load phase+1 as held in the preceding cycle, i.e. the number of cycles between consecutive rise_pulses.
REQ-020 period SHALL not update on the first rise after IDLE.
REQ-021 On fall_pulse, high_time SHALL load phase+1.
REQ-022 period and high_time SHALL hold their values between updates.
REQ-023 The FSM SHALL have states IDLE, MEASURE, TRACK and LOCKED, with IDLE as the reset state.
REQ-024 IDLE -> MEASURE on rise_pulse.
REQ-025 MEASURE -> TRACK on rise_pulse; the measured period loads the reference register (ref) and match_cnt is cleared to 0.
REQ-026 TRACK, on rise_pulse with |period_new - ref| <= TOL: match_cnt increments; the FSM moves to LOCKED when match_cnt reaches LOCK_COUNT.
REQ-027 TRACK, on rise_pulse with a mismatch: ref loads period_new and match_cnt clears.
REQ-028 LOCKED, on rise_pulse with a mismatch: the FSM goes to TRACK, ref loads period_new and match_cnt clears.
REQ-029 LOCKED, on rise_pulse with a match: the FSM stays in LOCKED and ref is unchanged.
REQ-030 Any state except IDLE, when phase reaches 2^CNT_W-1 with no rise_pulse: go to IDLE, set stall=1, clear match_cnt.
REQ-031 stall SHALL clear on the next rise_pulse; it SHALL also clear on rst.
REQ-032 If saturation and rise_pulse occur in the same cycle, rise_pulse SHALL win: normal transition, no stall.
REQ-033 locked SHALL be a registered output, high exactly while state == LOCKED.
REQ-034 locked SHALL rise in the cycle after the LOCK_COUNT-th matching rise_pulse.
REQ-035 The match comparison SHALL use an unsigned absolute difference computed at CNT_W+1 bits, with no wrap.

Reset
REQ-036 On rst = 1 at a clk edge, the following SHALL reset to 0: sync flops, edge register, phase, period, high_time, ref, match_cnt, rise_pulse, fall_pulse, locked and stall; the state SHALL go to IDLE.
REQ-037 rst asserted mid-operation, including in LOCKED, SHALL take effect on that same edge with no residual pulses.
REQ-038 The first edge detection after reset release SHALL require a real div_in transition; a div_in that is already high SHALL NOT produce a rise_pulse.

Structure
REQ-039 A shared package SHALL hold the FSM state encoding (2 bits) and the default values of CNT_W, LOCK_COUNT and TOL.
REQ-040 The synchronizer and edge detector SHALL be one sub-module, sync_edge (ports: clk, rst, d_in, rise, fall), reusable by other SAM input monitors.
REQ-041 Counters, capture registers and the FSM SHALL live in clk_div_monitor.

Verification
REQ-042 Reset, then div_in = clk/4 (2 high, 2 low) -> after the 1st rise: period=0; after the 2nd: period=4, high_time=2; locked=1 one cycle after the 6th rise_pulse.
REQ-043 Locked on clk/4, then one period of 5 cycles -> locked stays 1 (within TOL); a following period of 7 -> locked=0, state TRACK, ref=7.
REQ-044 div_in held low for 300 cycles while LOCKED -> phase saturates at 255, locked=0, stall=1; the next rise clears stall, state MEASURE.
REQ-045 rst pulsed for one cycle while LOCKED -> next cycle: locked=0, period=0, phase=0, no rise/fall pulses, state IDLE.
REQ-046 div_in toggling asynchronously to clk (clk/8, random skew) -> exactly one rise_pulse and one fall_pulse per div_in cycle; period in {7,8,9}; locked=1.

Source files
------------

// File: rtl/clk_div_monitor_pkg.sv
// Shared definitions for the divided-clock monitor: FSM state encoding and
// the default sizing/tolerance values used by the top module.
package clk_div_monitor_pkg;

  // Default width of the phase, period and high-time counters.
  localparam int DEF_CNT_W      = 8;
  // Default number of consecutive matching periods needed to report lock.
  localparam int DEF_LOCK_COUNT = 4;
  // Default tolerance, in clk cycles, between a new period and the reference.
  localparam int DEF_TOL        = 1;

  // Monitor FSM states (2-bit encoding, also exported on the debug port).
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_LOCKED  = 2'd3
  } mon_state_t;

endpackage

// File: rtl/clk_div_monitor_sync_edge.sv
// Two-flop synchronizer plus edge register for a slow asynchronous input.
// rise/fall are single-cycle combinational strobes derived from the
// synchronized value and the edge register; callers register them if they
// need a registered pulse. After reset the strobes stay quiet until the edge
// register holds a real sample, so a level that is already high when reset
// releases is not mistaken for a rising edge.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic rise,
  output logic fall
);

  logic       sync1;
  logic       sync2;
  logic       edge_q;
  // vld[0]: sync1 holds a real sample, vld[1]: sync2 does, vld[2]: edge_q does
  logic [2:0] vld;

  // Synchronizer chain, edge register and sample-validity tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      edge_q <= 1'b0;
      vld    <= 3'b000;
    end else begin
      sync1  <= d_in;
      sync2  <= sync1;
      edge_q <= sync2;
      vld    <= {vld[1:0], 1'b1};
    end
  end

  // Edge strobes are mutually exclusive because they compare the same pair
  assign rise = vld[2] &  sync2 & ~edge_q;
  assign fall = vld[2] & ~sync2 &  edge_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor. Detects edges of an asynchronous divided clock,
// measures its period and high time in system clock cycles, and reports
// whether the period is stable (locked) or has stopped toggling (stall).
//
// Timing overview:
//   - rise_ev/fall_ev come from sync_edge one cycle before the registered
//     rise_pulse/fall_pulse outputs; counters and capture registers update
//     on that same edge, so phase reads 0 and period/high_time already hold
//     their new values in the cycle where the pulse is visible.
//   - The FSM reacts to the registered rise_pulse, comparing the freshly
//     captured period against the reference; its state (and locked) change
//     in the cycle after rise_pulse.
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int TOL        = DEF_TOL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] phase,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             stall,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_ref_period
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] PH_MAX = '1;

  mon_state_t       state;
  logic [CNT_W-1:0] ref_period;
  logic [MC_W-1:0]  match_cnt;

  logic             rise_ev;
  logic             fall_ev;
  logic [CNT_W:0]   phase_inc;
  logic [CNT_W-1:0] period_new;
  logic [CNT_W:0]   period_diff;
  logic             period_match;
  logic [MC_W:0]    cnt_inc;
  logic             lock_hit;
  logic             sat_hit;

  sync_edge u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .d_in (div_in),
    .rise (rise_ev),
    .fall (fall_ev)
  );

  // phase+1 is formed one bit wider so a saturated phase cannot wrap to 0
  assign phase_inc  = {1'b0, phase} + {{CNT_W{1'b0}}, 1'b1};
  assign period_new = phase_inc[CNT_W] ? PH_MAX : phase_inc[CNT_W-1:0];

  // Unsigned |period - ref| at CNT_W+1 bits; the larger operand is always
  // the minuend, so the result never wraps
  always_comb begin
    period_diff = '0;
    if (period >= ref_period) begin
      period_diff = {1'b0, period} - {1'b0, ref_period};
    end else begin
      period_diff = {1'b0, ref_period} - {1'b0, period};
    end
  end

  assign period_match = (period_diff <= (CNT_W+1)'(TOL));

  // Match counter increment, checked against the lock threshold
  assign cnt_inc  = {1'b0, match_cnt} + {{MC_W{1'b0}}, 1'b1};
  assign lock_hit = (cnt_inc >= (MC_W+1)'(LOCK_COUNT));

  // Saturation timeout: a pending rise on this edge takes priority
  assign sat_hit = (state != ST_IDLE) && (phase == PH_MAX) && !rise_ev;

  // Registered edge pulses, phase counter and period/high-time capture
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      phase      <= '0;
      period     <= '0;
      high_time  <= '0;
    end else begin
      rise_pulse <= rise_ev;
      fall_pulse <= fall_ev;
      if (rise_ev) begin
        phase <= '0;
      end else if (phase != PH_MAX) begin
        phase <= phase_inc[CNT_W-1:0];
      end
      // The first rise after IDLE only opens the measurement window
      if (rise_ev && (state != ST_IDLE)) begin
        period <= period_new;
      end
      if (fall_ev) begin
        high_time <= period_new;
      end
    end
  end

  // Lock FSM with registered locked/stall outputs and reference tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ref_period <= '0;
      match_cnt  <= '0;
      locked     <= 1'b0;
      stall      <= 1'b0;
    end else if (rise_pulse) begin
      stall <= 1'b0;
      case (state)
        ST_IDLE: begin
          state  <= ST_MEASURE;
          locked <= 1'b0;
        end
        ST_MEASURE: begin
          state      <= ST_TRACK;
          locked     <= 1'b0;
          ref_period <= period;
          match_cnt  <= '0;
        end
        ST_TRACK: begin
          if (period_match) begin
            match_cnt <= cnt_inc[MC_W-1:0];
            if (lock_hit) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end
          end else begin
            ref_period <= period;
            match_cnt  <= '0;
          end
        end
        ST_LOCKED: begin
          if (!period_match) begin
            state      <= ST_TRACK;
            locked     <= 1'b0;
            ref_period <= period;
            match_cnt  <= '0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          locked <= 1'b0;
        end
      endcase
    end else if (sat_hit) begin
      state     <= ST_IDLE;
      locked    <= 1'b0;
      stall     <= 1'b1;
      match_cnt <= '0;
    end
  end

  assign dbg_state      = state;
  assign dbg_ref_period = ref_period;

endmodule
